// File: rtl/fpu_pkg.sv
// Shared FPU front-end types: instruction width, the issue NOP, and the queue entry
// layout that the FPU decode also uses.
package fpu_pkg;
  localparam int FP_INST_W = 32;
  localparam logic [FP_INST_W-1:0] FP_NOP_INST = 32'h0;

  typedef struct packed {
    logic [FP_INST_W-1:0] inst;
    logic [31:0]          intreg;
  } fpu_entry_t;
endpackage

// File: rtl/fpu_issue_queue_if.sv
// Handshake bundle between decode, the FP issue queue and the FPU.
// The queue sits on the slave side; the decode/FPU environment is the master.
interface fpu_issue_queue_if;
  import fpu_pkg::*;

  logic                 in_valid;
  logic [FP_INST_W-1:0] in_inst;
  logic [31:0]          in_intreg;
  logic                 in_ready;
  logic [FP_INST_W-1:0] fpu_inst;
  logic [31:0]          fpu_from_intreg;
  logic                 fpu_is_legl;
  logic                 fpu_hazard;

  modport master (
    output in_valid, in_inst, in_intreg, fpu_hazard,
    input  in_ready, fpu_inst, fpu_from_intreg, fpu_is_legl
  );

  modport slave (
    input  in_valid, in_inst, in_intreg, fpu_hazard,
    output in_ready, fpu_inst, fpu_from_intreg, fpu_is_legl
  );
endinterface

// File: rtl/fpu_iq_storage.sv
// Entry array for the FP issue queue: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's count.
module fpu_iq_storage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  fpu_entry_t       wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output fpu_entry_t       rd_data
);

  fpu_entry_t mem_q [DEPTH];
  fpu_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue in front of the FPU: buffers decode traffic, holds the head while
// the FPU reports a hazard, and keeps saturating issue/stall performance counters.
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             flush,
  fpu_issue_queue_if.slave io,
  output logic             empty,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       push, pop, stall, is_legl;
  fpu_entry_t wr_entry, head;

  assign empty       = (count_q == '0);
  assign io.in_ready = (count_q != FULL_CNT);

  // Issue strobe depends on the hazard, but the head data depends only on state, so no loop.
  assign is_legl        = clken & ~empty & ~io.fpu_hazard;
  assign io.fpu_is_legl = is_legl;
  assign io.fpu_inst        = empty ? FP_NOP_INST : head.inst;
  assign io.fpu_from_intreg = empty ? 32'h0 : head.intreg;

  assign push  = clken & io.in_valid & io.in_ready & ~flush;
  assign pop   = is_legl & ~flush;
  assign stall = clken & ~empty & io.fpu_hazard & ~flush;

  assign wr_entry = '{inst: io.in_inst, intreg: io.in_intreg};

  fpu_iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .wr_en  (push),
    .wr_ptr (wr_ptr_q),
    .wr_data(wr_entry),
    .rd_ptr (rd_ptr_q),
    .rd_data(head)
  );

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clken && flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
      if (pop)   issue_cnt_d = sat_inc(issue_cnt_q);
      if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios followed by random traffic, checked against a
// queue-based reference model by a negedge monitor.
module tb_fpu_issue_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clken = 1'b1;
  logic flush = 1'b0;
  logic empty;
  logic [CNT_W-1:0] issue_cnt, stall_cnt;

  fpu_issue_queue_if bus();

  fpu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .flush    (flush),
    .io       (bus),
    .empty    (empty),
    .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue contents as a plain SV queue plus two counters.
  fpu_entry_t mq[$];
  logic [CNT_W-1:0] m_issue = '0;
  logic [CNT_W-1:0] m_stall = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_issue = '0;
      m_stall = '0;
    end else if (clken) begin
      int n;
      n = mq.size();
      if (flush) begin
        mq.delete();
      end else begin
        if (n > 0 && !bus.fpu_hazard) begin
          void'(mq.pop_front());
          if (m_issue != CNT_MAX) m_issue = m_issue + 1'b1;
        end
        if (n > 0 && bus.fpu_hazard && m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
        if (bus.in_valid && n < DEPTH) mq.push_back('{inst: bus.in_inst, intreg: bus.in_intreg});
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge compare the DUT against the model's view.
  always @(negedge clk) begin
    logic exp_legl;
    exp_legl = clken && (mq.size() > 0) && !bus.fpu_hazard;
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("is_legl", 64'(bus.fpu_is_legl), 64'(exp_legl));
    if (mq.size() > 0) begin
      chk("fpu_inst", 64'(bus.fpu_inst), 64'(mq[0].inst));
      chk("fpu_from_intreg", 64'(bus.fpu_from_intreg), 64'(mq[0].intreg));
    end else begin
      chk("fpu_inst_nop", 64'(bus.fpu_inst), 64'(FP_NOP_INST));
      chk("fpu_from_intreg_zero", 64'(bus.fpu_from_intreg), 64'h0);
    end
    chk("issue_cnt", 64'(issue_cnt), 64'(m_issue));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r,
                       input logic hz, input logic fl, input logic ce);
    bus.in_valid   = v;
    bus.in_inst    = i;
    bus.in_intreg  = r;
    bus.fpu_hazard = hz;
    flush          = fl;
    clken          = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic hz);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, hz, 1'b0, 1'b1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.in_intreg = '0;
    bus.fpu_hazard = 1'b0;
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);

    // Reset mid-stream with three entries held behind a hazard.
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h100 + k, 32'h200 + k, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    idle(1, 1'b0);

    // Single fadd through an idle queue.
    drive(1'b1, 32'h0020_80D3, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Fill behind a hazard, try a fifth push, then drain in order.
    for (int k = 0; k < 5; k++) drive(1'b1, 32'hA000 + k, 32'hB000 + k, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    idle(5, 1'b0);

    // Steady stream with pointer wrap.
    for (int k = 0; k < 10; k++) drive(1'b1, 32'hC000 + k, 32'hD000 + k, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Flush with a simultaneous push and an issuable head.
    for (int k = 0; k < 2; k++) drive(1'b1, 32'hE000 + k, 32'hF000 + k, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'hEEEE, 32'hFFFF, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);

    // Clock enable low while decode keeps offering.
    for (int k = 0; k < 2; k++) drive(1'b1, 32'h7000 + k, 32'h8000 + k, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h7777, 32'h8888, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Random traffic, long enough between resets to saturate the narrow counters.
    for (int k = 0; k < 600; k++) begin
      if (k == 450) rst = 1'b1;
      if (k == 452) rst = 1'b0;
      drive($urandom_range(0, 99) < 60, $urandom, $urandom,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 90);
    end
    idle(6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
